// File: rtl/ethernet_mii_frame_tx.sv
// Ethernet II MAC transmit stage: byte stream to MII nibbles with pad/IFG.
// Define ETH_MII_TX_FCS_EN to generate and append the CRC-32 FCS.
module ethernet_mii_frame_tx #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_clk,
  output logic        tx_en,
  output logic [3:0]  tx_d,
  input  logic [47:0] dest_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, IFG
  } state_e;

  localparam int GW = $clog2(2 * IFG_BYTES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(2 * IFG_BYTES - 1);
  localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME_BYTES);

`ifdef ETH_MII_TX_FCS_EN
  localparam state_e TAIL = FCS;
`else
  localparam state_e TAIL = IFG;
`endif

  logic [2:0]    sync_q;
  logic          tick;
  state_e        state_q;
  state_e        eff;
  logic          phase_q;
  logic [3:0]    idx_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    byte_q;
  logic          last_q;
  logic [111:0]  hdr_q;
  logic [10:0]   cnt_q;
  logic [10:0]   cnt_inc;
  logic          discard_q;
  logic          tx_en_q;
  logic [3:0]    tx_d_q;
  logic          underrun_q;
  logic          busy_q;
  logic [15:0]   fc_q;
  logic          start;
  logic          payload_due;
  logic          starve;
  logic          is_byte;
  logic [7:0]    cur_byte;
  logic [3:0]    nib;

`ifdef ETH_MII_TX_FCS_EN
  logic [31:0] crc_q;

  function automatic logic [31:0] crc_nib(
    input logic [31:0] c,
    input logic [3:0]  d
  );
    logic [31:0] r;
    r = c ^ {28'h0, d};
    for (int i = 0; i < 4; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], tx_clk};
  end

  assign tick = sync_q[2] & ~sync_q[1];

  assign start       = (state_q == IDLE) && s_valid && !discard_q;
  assign payload_due = (state_q == PAYLOAD) && !phase_q;
  assign starve      = payload_due && !s_valid;
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 11'd1;

  assign s_ready = tick && !reset && s_valid &&
                   (payload_due || discard_q);

  // A missing payload byte is replaced on the spot by pad or the tail.
  always_comb begin
    eff = state_q;
    if (start)
      eff = PREAMBLE;
    else if (starve)
      eff = (cnt_q < MIN_CNT) ? PAD : TAIL;
  end

  always_comb begin
    is_byte = eff inside {PREAMBLE, SFD, HEADER, PAYLOAD, PAD};
    case (eff)
      PREAMBLE: cur_byte = 8'h55;
      SFD:      cur_byte = 8'hD5;
      HEADER:   cur_byte = hdr_q[111:104];
      PAYLOAD:  cur_byte = s_data;
      default:  cur_byte = 8'h00;
    endcase
    nib = phase_q ? byte_q[7:4] : cur_byte[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      idx_q      <= '0;
      gap_q      <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      hdr_q      <= '0;
      cnt_q      <= '0;
      discard_q  <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_d_q     <= '0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
      fc_q       <= '0;
`ifdef ETH_MII_TX_FCS_EN
      crc_q      <= '1;
`endif
    end else begin
      underrun_q <= 1'b0;
      if (tick) begin
        state_q <= eff;
        tx_en_q <= 1'b0;
        tx_d_q  <= 4'h0;
        if (discard_q && s_valid && s_last)
          discard_q <= 1'b0;
        if (starve) begin
          underrun_q <= 1'b1;
          discard_q  <= 1'b1;
        end
        if (start) begin
          hdr_q  <= {dest_mac, src_mac, ethertype};
          cnt_q  <= '0;
          idx_q  <= '0;
          busy_q <= 1'b1;
`ifdef ETH_MII_TX_FCS_EN
          crc_q  <= '1;
`endif
        end
        if (is_byte) begin
          tx_en_q <= 1'b1;
          tx_d_q  <= nib;
          phase_q <= ~phase_q;
          if (!phase_q) begin
            byte_q <= cur_byte;
            if (eff == PAYLOAD) last_q <= s_last;
          end
`ifdef ETH_MII_TX_FCS_EN
          if (eff inside {HEADER, PAYLOAD, PAD})
            crc_q <= crc_nib(crc_q, nib);
`endif
        end
        if (phase_q) begin
          case (eff)
            PREAMBLE: begin
              idx_q <= idx_q + 4'd1;
              if (idx_q == 4'd6) begin
                state_q <= SFD;
                idx_q   <= '0;
              end
            end
            SFD: state_q <= HEADER;
            HEADER: begin
              hdr_q <= {hdr_q[103:0], 8'h00};
              cnt_q <= cnt_inc;
              idx_q <= idx_q + 4'd1;
              if (idx_q == 4'd13) begin
                state_q <= PAYLOAD;
                idx_q   <= '0;
              end
            end
            PAYLOAD: begin
              cnt_q <= cnt_inc;
              if (last_q)
                state_q <= (cnt_inc < MIN_CNT) ? PAD : TAIL;
            end
            PAD: begin
              cnt_q <= cnt_inc;
              if (cnt_inc >= MIN_CNT) state_q <= TAIL;
            end
            default: ;
          endcase
        end
`ifdef ETH_MII_TX_FCS_EN
        // FCS is the inverted CRC, shifted out low nibble first.
        if (eff == FCS) begin
          tx_en_q <= 1'b1;
          tx_d_q  <= ~crc_q[3:0];
          crc_q   <= {4'h0, crc_q[31:4]};
          idx_q   <= idx_q + 4'd1;
          if (idx_q == 4'd7) begin
            state_q <= IFG;
            idx_q   <= '0;
          end
        end
`endif
        if (eff == IFG) begin
          gap_q <= gap_q + GW'(1);
          if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            fc_q    <= fc_q + 16'd1;
          end
        end
      end
    end
  end

  assign tx_en       = tx_en_q;
  assign tx_d        = tx_d_q;
  assign busy        = busy_q;
  assign underrun    = underrun_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_ethernet_mii_frame_tx.sv
// Scoreboard bench for ethernet_mii_frame_tx: random frames, underrun,
// back-to-back gap and reset abort, checked against a byte-level model.
module tb_ethernet_mii_frame_tx;
  localparam int MINF = 60;
  localparam int IFG  = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_clk = 1'b0;
  logic        tx_en;
  logic [3:0]  tx_d;
  logic [47:0] dest_mac = '0;
  logic [47:0] src_mac = '0;
  logic [15:0] ethertype = '0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        busy;
  logic        underrun;
  logic [15:0] frame_count;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] pl [0:127];
  logic [3:0] exp_nib [$];
  int exp_len [$];
  int exp_gap [$];
  logic [3:0] got [$];
  bit in_frame = 0;
  int gap_cnt = 0;
  int gap_before = 0;
  int ucount = 0;
  int exp_fc = 0;

  ethernet_mii_frame_tx #(.MIN_FRAME_BYTES(MINF), .IFG_BYTES(IFG)) dut (
    .clk(clk), .reset(reset), .tx_clk(tx_clk),
    .tx_en(tx_en), .tx_d(tx_d),
    .dest_mac(dest_mac), .src_mac(src_mac), .ethertype(ethertype),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .busy(busy), .underrun(underrun),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  initial begin
    #2;
    forever #40 tx_clk = ~tx_clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input longint act,
                       input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] crc8(input logic [31:0] c,
                                       input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Reference frame: preamble, SFD, header, payload, pad, optional FCS.
  task automatic push_frame(input int n, input int gap);
    logic [7:0] b [$];
    logic [111:0] h;
`ifdef ETH_MII_TX_FCS_EN
    logic [31:0] c;
`endif
    for (int i = 0; i < 7; i++) b.push_back(8'h55);
    b.push_back(8'hD5);
    h = {dest_mac, src_mac, ethertype};
    for (int i = 0; i < 14; i++) b.push_back(h[111-8*i -: 8]);
    for (int i = 0; i < n; i++) b.push_back(pl[i]);
    while (b.size() - 8 < MINF) b.push_back(8'h00);
`ifdef ETH_MII_TX_FCS_EN
    c = 32'hFFFFFFFF;
    for (int i = 8; i < b.size(); i++) c = crc8(c, b[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) b.push_back(c[8*i +: 8]);
`endif
    foreach (b[i]) begin
      exp_nib.push_back(b[i][3:0]);
      exp_nib.push_back(b[i][7:4]);
    end
    exp_len.push_back(2 * b.size());
    exp_gap.push_back(gap);
  endtask

  task automatic end_frame();
    int len, g, bad;
    logic [3:0] e;
`ifdef ETH_MII_TX_FCS_EN
    logic [31:0] c;
`endif
    if (exp_len.size() == 0) begin
      check("unexpected_frame", 1, 0);
      return;
    end
    len = exp_len.pop_front();
    g = exp_gap.pop_front();
    if (len == 0) return;
    check("frame_nibbles", got.size(), len);
    bad = 0;
    for (int i = 0; i < len; i++) begin
      e = exp_nib.pop_front();
      if (i >= got.size()) bad++;
      else if (got[i] != e) bad++;
    end
    check("frame_content_errors", bad, 0);
    if (g >= 0) check("ifg_ticks", gap_before, g);
`ifdef ETH_MII_TX_FCS_EN
    c = 32'hFFFFFFFF;
    for (int i = 16; i + 1 < got.size(); i += 2)
      c = crc8(c, {got[i+1], got[i]});
    check("fcs_residue", c, 32'hDEBB20E3);
`endif
  endtask

  always @(posedge tx_clk) begin
    if (tx_en) begin
      if (!in_frame) begin
        in_frame = 1;
        got.delete();
        gap_before = gap_cnt;
      end
      got.push_back(tx_d);
    end else if (in_frame) begin
      in_frame = 0;
      gap_cnt = 1;
      end_frame();
    end else begin
      gap_cnt++;
    end
  end

  always @(negedge clk) if (underrun) ucount++;

  task automatic rand_hdr();
    dest_mac  = {16'($urandom), 32'($urandom)};
    src_mac   = {16'($urandom), 32'($urandom)};
    ethertype = 16'h0800;
  endtask

  task automatic rand_pl(input int n);
    for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
  endtask

  task automatic feed(input int from, input int to, input int last,
                      output int cnt);
    int k;
    cnt = 0;
    for (int i = from; i < to; i++) begin
      s_valid = 1'b1;
      s_data  = pl[i];
      s_last  = (i == last);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!s_ready && k < 6000);
      if (!s_ready) begin
        s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic send(input int n, input int gap, input bit hold);
    int c;
    push_frame(n, gap);
    feed(0, n, n - 1, c);
    check("payload_consumed", c, n);
    if (!hold) s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 8000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_busy_timeout"}, busy, 0);
    @(negedge clk);
    check({name, "_frame_count"}, frame_count, exp_fc);
  endtask

  initial begin
    int c, k, u0, n;
    repeat (4) @(negedge clk);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_d", tx_d, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_count", frame_count, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    dest_mac  = 48'h0123456789AB;
    src_mac   = 48'h02AABBCCDDEE;
    ethertype = 16'h0800;
    pl[0] = 8'hAB;
    send(1, -1, 0);
    exp_fc++;
    wait_idle("min_pad");

    rand_hdr();
    for (int i = 0; i < 46; i++) pl[i] = 8'(i);
    send(46, -1, 0);
    exp_fc++;
    wait_idle("no_pad");

    rand_hdr();
    n = $urandom_range(1, 60);
    rand_pl(n);
    send(n, -1, 1);
    rand_hdr();
    n = $urandom_range(1, 60);
    rand_pl(n);
    send(n, 2 * IFG, 0);
    exp_fc += 2;
    wait_idle("b2b");

    rand_hdr();
    rand_pl(10);
    u0 = ucount;
    push_frame(3, -1);
    feed(0, 3, 9, c);
    check("ur_head_consumed", c, 3);
    s_valid = 1'b0;
    k = 0;
    while (ucount == u0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("ur_pulse_seen", ucount - u0, 1);
    feed(3, 10, 9, c);
    check("ur_discard_consumed", c, 7);
    s_valid = 1'b0;
    exp_fc++;
    wait_idle("underrun");
    check("ur_pulse_count", ucount - u0, 1);

    for (int f = 0; f < 4; f++) begin
      rand_hdr();
      n = $urandom_range(1, 64);
      rand_pl(n);
      send(n, -1, 0);
      exp_fc++;
      wait_idle("random");
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end

    rand_hdr();
    rand_pl(8);
    exp_len.push_back(0);
    exp_gap.push_back(-1);
    s_valid = 1'b1;
    s_data  = pl[0];
    s_last  = 1'b0;
    k = 0;
    while (!(in_frame && got.size() >= 20) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("abort_in_header", (in_frame && got.size() >= 20), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("abort_tx_en", tx_en, 0);
    check("abort_tx_d", tx_d, 0);
    check("abort_busy", busy, 0);
    check("abort_underrun", underrun, 0);
    check("abort_s_ready", s_ready, 0);
    check("abort_frame_count", frame_count, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_fc = 0;
    repeat (20) @(negedge clk);

    rand_hdr();
    n = $urandom_range(20, 50);
    rand_pl(n);
    send(n, -1, 0);
    exp_fc++;
    wait_idle("after_abort");

    repeat (200) @(negedge clk);
    check("frames_outstanding", exp_len.size(), 0);
    check("underrun_total", ucount, 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
